// File: rtl/add8u_err_monitor_pkg.sv
// Shared widths and FSM state type for the approximate-adder error monitor.
package add8u_err_monitor_pkg;

  localparam int OP_W  = 8;
  localparam int ERR_W = 9;
  localparam int SUM_W = 25;
  localparam int CNT_W = 17;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/add8u_err_calc.sv
// Combinational exact 8-bit sum and 9-bit absolute error against an approximate sum.
module add8u_err_calc
  import add8u_err_monitor_pkg::*;
(
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic [ERR_W-1:0] approx,
  output logic [ERR_W-1:0] exact,
  output logic [ERR_W-1:0] err
);

  always_comb begin
    exact = {1'b0, a} + {1'b0, b};
    if (exact >= approx) begin
      err = exact - approx;
    end else begin
      err = approx - exact;
    end
  end

endmodule

// File: rtl/add8u_err_monitor.sv
// Windowed error statistics for an approximate 8-bit adder: register the error,
// accumulate sum/max/nonzero-count over WINDOW samples, then hold the result.
module add8u_err_monitor
  import add8u_err_monitor_pkg::*;
#(
  parameter int WINDOW = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic [ERR_W-1:0] in_approx,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SUM_W-1:0] res_sum_abs_err,
  output logic [ERR_W-1:0] res_max_err,
  output logic [CNT_W-1:0] res_err_count
);

  // Handshake: a transfer happens on a rising edge only when valid and ready
  // are both high; valid may not depend on ready, and held results never change.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
  logic             s1_valid_q, s1_valid_d;
  logic [ERR_W-1:0] s1_err_q, s1_err_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [ERR_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [ERR_W-1:0] calc_exact;
  logic [ERR_W-1:0] calc_err;
  logic             in_xfer;

  add8u_err_calc u_calc (
    .a      (in_a),
    .b      (in_b),
    .approx (in_approx),
    .exact  (calc_exact),
    .err    (calc_err)
  );

  // Gating with rst_n keeps in_ready low for the whole time reset is asserted.
  assign in_ready        = (state_q == ACCUM) && rst_n;
  assign res_valid       = (state_q == HOLD);
  assign in_xfer         = in_valid && in_ready;
  assign res_sum_abs_err = sum_q;
  assign res_max_err     = max_q;
  assign res_err_count   = err_cnt_q;

  always_comb begin
    state_d    = state_q;
    smp_cnt_d  = smp_cnt_q;
    s1_valid_d = in_xfer;
    s1_err_d   = in_xfer ? calc_err : s1_err_q;
    sum_d      = sum_q;
    max_d      = max_q;
    err_cnt_d  = err_cnt_q;

    if (s1_valid_q) begin
      sum_d     = sum_q + SUM_W'(s1_err_q);
      max_d     = (s1_err_q > max_q) ? s1_err_q : max_q;
      err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, |s1_err_q};
    end

    case (state_q)
      ACCUM: begin
        if (in_xfer) begin
          smp_cnt_d = smp_cnt_q + 1'b1;
          if (smp_cnt_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: state_d = HOLD;
      HOLD: begin
        // Stage 1 is empty here, so clearing cannot lose a pending sample.
        if (res_ready) begin
          state_d   = ACCUM;
          smp_cnt_d = '0;
          sum_d     = '0;
          max_d     = '0;
          err_cnt_d = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      smp_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_err_q   <= '0;
      sum_q      <= '0;
      max_q      <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      smp_cnt_q  <= smp_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_add8u_err_monitor.sv
// Directed bench for add8u_err_monitor: WINDOW=4 instance for directed windows,
// WINDOW=256 instance for a gapped random window against a bench-side model.
module tb_add8u_err_monitor;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, res_valid, res_ready;
  logic [7:0]  in_a, in_b;
  logic [8:0]  in_approx;
  logic [24:0] res_sum;
  logic [8:0]  res_max;
  logic [16:0] res_cnt;

  logic        w_in_valid, w_in_ready, w_res_valid, w_res_ready;
  logic [7:0]  w_in_a, w_in_b;
  logic [8:0]  w_in_approx;
  logic [24:0] w_res_sum;
  logic [8:0]  w_res_max;
  logic [16:0] w_res_cnt;

  int checks = 0;
  int errors = 0;

  add8u_err_monitor #(.WINDOW(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum_abs_err(res_sum), .res_max_err(res_max), .res_err_count(res_cnt)
  );

  add8u_err_monitor #(.WINDOW(256)) dut256 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_a(w_in_a), .in_b(w_in_b), .in_approx(w_in_approx),
    .res_valid(w_res_valid), .res_ready(w_res_ready),
    .res_sum_abs_err(w_res_sum), .res_max_err(w_res_max), .res_err_count(w_res_cnt)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] ap);
    in_a = a; in_b = b; in_approx = ap; in_valid = 1'b1;
    #1;
    check("in_ready_accum", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called right after the edge accepting sample 4: DRAIN cycle, then HOLD.
  task automatic expect_result(input string tag, input int s, input int m, input int c);
    check({tag, "_drain_valid"}, {31'b0, res_valid}, 32'd0);
    check({tag, "_drain_ready"}, {31'b0, in_ready}, 32'd0);
    tick(1);
    check({tag, "_res_valid"}, {31'b0, res_valid}, 32'd1);
    check({tag, "_sum"}, {7'b0, res_sum}, s);
    check({tag, "_max"}, {23'b0, res_max}, m);
    check({tag, "_cnt"}, {15'b0, res_cnt}, c);
    check({tag, "_hold_ready"}, {31'b0, in_ready}, 32'd0);
  endtask

  task automatic take_result(input string tag);
    res_ready = 1'b1;
    #1;
    check({tag, "_no_same_cycle_accept"}, {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check({tag, "_after_take_valid"}, {31'b0, res_valid}, 32'd0);
    check({tag, "_after_take_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  int          accepted;
  int          cyc;
  int          exp_sum, exp_max, exp_cnt;
  logic [7:0]  ra, rb;
  logic [8:0]  rex, rap, rerr;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = '0; res_ready = 1'b0;
    w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_in_approx = '0; w_res_ready = 1'b0;

    // Reset state
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("rst_sum", {7'b0, res_sum}, 32'd0);
    check("rst_max", {23'b0, res_max}, 32'd0);
    check("rst_cnt", {15'b0, res_cnt}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", {31'b0, in_ready}, 32'd1);

    // Exact approximations: all-zero result
    send(8'd1, 8'd2, 9'd3);
    send(8'd100, 8'd50, 9'd150);
    send(8'd255, 8'd255, 9'd510);
    send(8'd0, 8'd0, 9'd0);
    expect_result("w_exact", 0, 0, 0);
    take_result("w_exact");

    // Mixed errors with idle gaps between samples
    send(8'd4, 8'd4, 9'd8);
    tick(2);
    send(8'd255, 8'd255, 9'd495);
    send(8'd1, 8'd0, 9'd0);
    tick(3);
    check("gap_no_result", {31'b0, res_valid}, 32'd0);
    send(8'd10, 8'd5, 9'd20);
    expect_result("w_mixed", 21, 15, 3);

    // Back-pressure: result stable and input blocked for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_res_valid", {31'b0, res_valid}, 32'd1);
      check("bp_sum", {7'b0, res_sum}, 32'd21);
      check("bp_max", {23'b0, res_max}, 32'd15);
      check("bp_cnt", {15'b0, res_cnt}, 32'd3);
    end
    take_result("w_mixed");

    // Reset mid-window discards the partial window
    send(8'd0, 8'd0, 9'd5);
    send(8'd0, 8'd0, 9'd7);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    check("midrst_res_valid", {31'b0, res_valid}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    check("midrst_no_result", {31'b0, res_valid}, 32'd0);
    check("midrst_sum_clear", {7'b0, res_sum}, 32'd0);

    // Fresh window including the maximum error 511 (approx beyond 510)
    send(8'd0, 8'd0, 9'd511);
    send(8'd3, 8'd3, 9'd6);
    send(8'd20, 8'd0, 9'd10);
    send(8'd7, 8'd1, 9'd0);
    expect_result("w_max511", 529, 511, 3);
    take_result("w_max511");

    // WINDOW=256 with random input gaps against a bench-side model
    accepted = 0; cyc = 0; exp_sum = 0; exp_max = 0; exp_cnt = 0;
    while (accepted < 256 && cyc < 3000) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rex = {1'b0, ra} + {1'b0, rb};
      rap = ($urandom_range(0, 1) == 0) ? rex : 9'($urandom_range(0, 511));
      w_in_a = ra; w_in_b = rb; w_in_approx = rap;
      w_in_valid = ($urandom_range(0, 3) != 0);
      #1;
      if (w_in_valid && w_in_ready) begin
        rerr = (rex >= rap) ? (rex - rap) : (rap - rex);
        exp_sum += int'(rerr);
        if (int'(rerr) > exp_max) exp_max = int'(rerr);
        if (rerr != 9'd0) exp_cnt++;
        accepted++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    w_in_valid = 1'b0;
    check("w256_accepted", accepted, 32'd256);
    check("w256_ready_low", {31'b0, w_in_ready}, 32'd0);
    cyc = 0;
    while (!w_res_valid && cyc < 5) begin
      tick(1);
      cyc++;
    end
    check("w256_latency", cyc, 32'd1);
    check("w256_sum", {7'b0, w_res_sum}, exp_sum);
    check("w256_max", {23'b0, w_res_max}, exp_max);
    check("w256_cnt", {15'b0, w_res_cnt}, exp_cnt);
    w_res_ready = 1'b1;
    tick(1);
    w_res_ready = 1'b0;
    check("w256_after_take", {31'b0, w_in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
